// File: rtl/mem_access_unit.sv
// EX/MEM memory access stage: issues single data-bus transactions for loads and stores,
// stalls the pipeline while the bus is busy, and hands a registered result to MEM/WB.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid_ex_i,
  input  logic [31:0] pc_ex_i,
  input  logic        rf_we_ex_i,
  input  logic [4:0]  wr_ex_i,
  input  logic [31:0] alu_res_ex_i,
  input  logic [31:0] wdata_ex_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] pc_mem_o,
  output logic        instr_valid_mem_o,
  output logic        rf_we_mem_o,
  output logic [4:0]  wr_mem_o,
  output logic [31:0] wd_mem_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [31:0] lpc_r, lpc_s;
  logic        lrf_we_r, lrf_we_s;
  logic [4:0]  lwr_r, lwr_s;
  logic [1:0]  loff_r, loff_s, lsize_r, lsize_s;
  logic        luns_r, luns_s;
  logic        req_r, req_s, bwe_r, bwe_s;
  logic [31:0] addr_r, addr_s, bwdata_r, bwdata_s;
  logic [3:0]  be_r, be_s;
  logic [31:0] pc_r, pc_s, wd_r, wd_s;
  logic        valid_r, valid_s, rf_we_r, rf_we_s, mis_r, mis_s, tmo_r, tmo_s;
  logic [4:0]  wr_r, wr_s;
  logic        stall_s, is_mem_s, misal_s;
  logic [3:0]  be_calc_s;
  logic [31:0] wdata_calc_s, shifted_s, load_s;

  // Access decode for the incoming instruction and load-data extraction for the pending one
  always_comb begin
    is_mem_s  = instr_valid_ex_i & (mem_re_i | mem_we_i);
    shifted_s = dmem_rdata_i >> {loff_r, 3'b000};
    case (mem_size_i)
      2'b00: begin
        misal_s      = 1'b0;
        be_calc_s    = 4'b0001 << alu_res_ex_i[1:0];
        wdata_calc_s = {4{wdata_ex_i[7:0]}};
      end
      2'b01: begin
        misal_s      = alu_res_ex_i[0];
        be_calc_s    = 4'b0011 << {alu_res_ex_i[1], 1'b0};
        wdata_calc_s = {2{wdata_ex_i[15:0]}};
      end
      default: begin
        misal_s      = (alu_res_ex_i[1:0] != 2'b00);
        be_calc_s    = 4'b1111;
        wdata_calc_s = wdata_ex_i;
      end
    endcase
    case (lsize_r)
      2'b00:   load_s = luns_r ? {24'd0, shifted_s[7:0]} : {{24{shifted_s[7]}}, shifted_s[7:0]};
      2'b01:   load_s = luns_r ? {16'd0, shifted_s[15:0]} : {{16{shifted_s[15]}}, shifted_s[15:0]};
      default: load_s = shifted_s;
    endcase
  end

  // Next-state, bus request and result computation
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    lpc_s    = lpc_r;
    lrf_we_s = lrf_we_r;
    lwr_s    = lwr_r;
    loff_s   = loff_r;
    lsize_s  = lsize_r;
    luns_s   = luns_r;
    req_s    = req_r;
    bwe_s    = bwe_r;
    addr_s   = addr_r;
    be_s     = be_r;
    bwdata_s = bwdata_r;
    pc_s     = pc_r;
    wr_s     = wr_r;
    wd_s     = wd_r;
    valid_s  = 1'b0;
    rf_we_s  = 1'b0;
    mis_s    = 1'b0;
    tmo_s    = 1'b0;
    stall_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_mem_s && !misal_s) begin
          lpc_s    = pc_ex_i;
          lrf_we_s = rf_we_ex_i & mem_re_i & ~mem_we_i & (wr_ex_i != 5'd0);
          lwr_s    = wr_ex_i;
          loff_s   = alu_res_ex_i[1:0];
          lsize_s  = mem_size_i;
          luns_s   = mem_unsigned_i;
          req_s    = 1'b1;
          bwe_s    = mem_we_i;
          addr_s   = {alu_res_ex_i[31:2], 2'b00};
          be_s     = be_calc_s;
          bwdata_s = wdata_calc_s;
          cnt_s    = 8'd0;
          state_s  = BUSY;
          stall_s  = 1'b1;
        end else if (instr_valid_ex_i) begin
          // Non-memory or misaligned: pass through in one cycle, misaligned never writes back
          valid_s = 1'b1;
          pc_s    = pc_ex_i;
          wr_s    = wr_ex_i;
          wd_s    = alu_res_ex_i;
          mis_s   = is_mem_s;
          rf_we_s = rf_we_ex_i & ~is_mem_s & (wr_ex_i != 5'd0);
        end else begin
          valid_s = 1'b0;
        end
      end
      BUSY: begin
        if (dmem_ack_i) begin
          req_s   = 1'b0;
          state_s = IDLE;
          valid_s = 1'b1;
          pc_s    = lpc_r;
          wr_s    = lwr_r;
          wd_s    = load_s;
          rf_we_s = lrf_we_r;
        end else if (cnt_r == 8'(MAX_WAIT - 1)) begin
          req_s   = 1'b0;
          state_s = IDLE;
          valid_s = 1'b1;
          pc_s    = lpc_r;
          wr_s    = lwr_r;
          tmo_s   = 1'b1;
          cnt_s   = cnt_r + 8'd1;
        end else begin
          cnt_s   = cnt_r + 8'd1;
          stall_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
      end
    endcase
  end

  // State and registered-output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 8'd0;
      lpc_r    <= 32'd0;
      lrf_we_r <= 1'b0;
      lwr_r    <= 5'd0;
      loff_r   <= 2'd0;
      lsize_r  <= 2'd0;
      luns_r   <= 1'b0;
      req_r    <= 1'b0;
      bwe_r    <= 1'b0;
      addr_r   <= 32'd0;
      be_r     <= 4'd0;
      bwdata_r <= 32'd0;
      pc_r     <= 32'd0;
      wr_r     <= 5'd0;
      wd_r     <= 32'd0;
      valid_r  <= 1'b0;
      rf_we_r  <= 1'b0;
      mis_r    <= 1'b0;
      tmo_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      lpc_r    <= lpc_s;
      lrf_we_r <= lrf_we_s;
      lwr_r    <= lwr_s;
      loff_r   <= loff_s;
      lsize_r  <= lsize_s;
      luns_r   <= luns_s;
      req_r    <= req_s;
      bwe_r    <= bwe_s;
      addr_r   <= addr_s;
      be_r     <= be_s;
      bwdata_r <= bwdata_s;
      pc_r     <= pc_s;
      wr_r     <= wr_s;
      wd_r     <= wd_s;
      valid_r  <= valid_s;
      rf_we_r  <= rf_we_s;
      mis_r    <= mis_s;
      tmo_r    <= tmo_s;
    end
  end

  // Stall is gated by reset so it drops immediately, even if EX presents a memory op
  assign stall_o           = stall_s & rst_n;
  assign dmem_req_o        = req_r;
  assign dmem_we_o         = bwe_r;
  assign dmem_addr_o       = addr_r;
  assign dmem_be_o         = be_r;
  assign dmem_wdata_o      = bwdata_r;
  assign pc_mem_o          = pc_r;
  assign instr_valid_mem_o = valid_r;
  assign rf_we_mem_o       = rf_we_r;
  assign wr_mem_o          = wr_r;
  assign wd_mem_o          = wd_r;
  assign misalign_o        = mis_r;
  assign timeout_o         = tmo_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver pushes expected results from a
// behavioural model; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_access_unit;
  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid_ex_i = 1'b0;
  logic [31:0] pc_ex_i = 32'd0;
  logic        rf_we_ex_i = 1'b0;
  logic [4:0]  wr_ex_i = 5'd0;
  logic [31:0] alu_res_ex_i = 32'd0;
  logic [31:0] wdata_ex_i = 32'd0;
  logic        mem_re_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [1:0]  mem_size_i = 2'd0;
  logic        mem_unsigned_i = 1'b0;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'd0;
  logic        dmem_req_o, dmem_we_o, stall_o, instr_valid_mem_o, rf_we_mem_o;
  logic        misalign_o, timeout_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, pc_mem_o, wd_mem_o;
  logic [3:0]  dmem_be_o;
  logic [4:0]  wr_mem_o;

  always #5 clk = ~clk;

  mem_access_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_ex_i(instr_valid_ex_i), .pc_ex_i(pc_ex_i), .rf_we_ex_i(rf_we_ex_i),
    .wr_ex_i(wr_ex_i), .alu_res_ex_i(alu_res_ex_i), .wdata_ex_i(wdata_ex_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_unsigned_i(mem_unsigned_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .pc_mem_o(pc_mem_o), .instr_valid_mem_o(instr_valid_mem_o),
    .rf_we_mem_o(rf_we_mem_o), .wr_mem_o(wr_mem_o), .wd_mem_o(wd_mem_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        chk_wd;
    logic        mis;
    logic        tmo;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  exp_t eq[$];
  bus_t bq[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_req = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: result stream and bus request against the scoreboard queues
  always @(negedge clk) begin
    if (!rst_n) begin
      bq.delete();
      prev_req = 1'b0;
    end else begin
      if (instr_valid_mem_o) begin
        if (eq.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          me = eq.pop_front();
          check("pc_mem", pc_mem_o, me.pc);
          check("rf_we_mem", {31'd0, rf_we_mem_o}, {31'd0, me.rf_we});
          check("wr_mem", {27'd0, wr_mem_o}, {27'd0, me.wr});
          check("misalign", {31'd0, misalign_o}, {31'd0, me.mis});
          check("timeout", {31'd0, timeout_o}, {31'd0, me.tmo});
          if (me.chk_wd) check("wd_mem", wd_mem_o, me.wd);
        end
      end else begin
        check("idle_flags", {29'd0, misalign_o, timeout_o, rf_we_mem_o}, 32'd0);
      end
      if (dmem_req_o) begin
        if (bq.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          check("bus_we", {31'd0, dmem_we_o}, {31'd0, bq[0].we});
          check("bus_addr", dmem_addr_o, bq[0].addr);
          check("bus_be", {28'd0, dmem_be_o}, {28'd0, bq[0].be});
          check("bus_wdata", dmem_wdata_o, bq[0].wdata);
        end
      end else if (prev_req && bq.size() > 0) begin
        void'(bq.pop_front());
      end
      prev_req = dmem_req_o;
    end
  end

  // Drive one EX/MEM instruction, run it to completion, and model its expected effect.
  // ack_cyc = BUSY cycle (1-based) in which the bus acks; > MW means it never does.
  task automatic issue(input bit v, input logic [31:0] pc, input bit rfwe, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] wd, input bit re, input bit we,
                       input logic [1:0] size, input bit uns, input int ack_cyc,
                       input logic [31:0] rdata);
    int     n, off, k, stalls, reqs, exp_cyc;
    bit     mem, mis, tmo, st;
    longint u, md;
    exp_t   e;
    bus_t   b;
    n   = 1 << size;
    off = int'(alu[1:0]);
    mem = re || we;
    mis = mem && ((off % n) != 0);
    tmo = v && mem && !mis && (ack_cyc > MW);
    exp_cyc = (v && mem && !mis) ? (tmo ? MW : ack_cyc) : 0;
    u  = longint'(rdata) >> (8 * off);
    md = longint'(1) << (8 * n);
    u  = u % md;
    if (!uns && u >= md / 2) u = u - md;
    e.pc     = pc;
    e.wr     = wr;
    e.rf_we  = rfwe && (wr != 5'd0) && !we && !mis && !tmo;
    e.wd     = mem ? u[31:0] : alu;
    e.chk_wd = !we && !mis && !tmo;
    e.mis    = mis;
    e.tmo    = tmo;
    if (v) eq.push_back(e);
    if (v && mem && !mis) begin
      b.we   = we;
      b.addr = {alu[31:2], 2'b00};
      b.be   = 4'((32'd1 << n) - 32'd1) << off;
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
      bq.push_back(b);
    end
    instr_valid_ex_i = v;    pc_ex_i = pc;        rf_we_ex_i = rfwe;  wr_ex_i = wr;
    alu_res_ex_i     = alu;  wdata_ex_i = wd;     mem_re_i = re;      mem_we_i = we;
    mem_size_i       = size; mem_unsigned_i = uns;
    k = 0; stalls = 0; reqs = 0;
    while (1) begin
      dmem_ack_i   = (k == 0) ? 1'($urandom_range(0, 1)) : (k == ack_cyc);
      dmem_rdata_i = (k > 0 && k == ack_cyc) ? rdata : $urandom;
      @(negedge clk);
      st = stall_o;
      if (dmem_req_o) reqs++;
      @(posedge clk); #1;
      if (!st) break;
      stalls++; k++;
      if (k > 4 * MW) begin
        check("stall_bound", k, 4 * MW);
        break;
      end
    end
    dmem_ack_i = 1'b0;
    check("stall_cycles", stalls, exp_cyc);
    check("req_cycles", reqs, exp_cyc);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_valid", {31'd0, instr_valid_mem_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_pc_wd", pc_mem_o | wd_mem_o | dmem_addr_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Directed: signed/unsigned byte loads, halfword store, misaligned, ack/timeout boundary
    issue(1, 32'h100, 1, 5'd5, 32'h1003, 32'h0, 1, 0, 2'b00, 0, 2, 32'h80123456);
    issue(1, 32'h104, 1, 5'd6, 32'h1003, 32'h0, 1, 0, 2'b00, 1, 2, 32'h80123456);
    issue(1, 32'h108, 1, 5'd7, 32'h2002, 32'h0000BEEF, 0, 1, 2'b01, 0, 1, 32'h0);
    issue(1, 32'h10C, 1, 5'd8, 32'h3001, 32'h0, 1, 0, 2'b10, 0, 1, 32'h0);
    issue(1, 32'h110, 1, 5'd9, 32'h3000, 32'h0, 1, 0, 2'b10, 0, MW + 5, 32'h0);
    issue(1, 32'h114, 1, 5'd10, 32'h3004, 32'h0, 1, 0, 2'b10, 0, MW, 32'hCAFEF00D);
    issue(1, 32'h118, 1, 5'd11, 32'h3008, 32'h0, 1, 0, 2'b10, 0, MW + 1, 32'h12345678);
    issue(1, 32'h11C, 1, 5'd12, 32'h400E, 32'h0, 1, 0, 2'b01, 0, 3, 32'h9ABC0000);
    issue(1, 32'h120, 1, 5'd0, 32'hDEADBEEF, 32'h0, 0, 0, 2'b00, 0, 1, 32'h0);
    issue(1, 32'h124, 1, 5'd13, 32'h4001, 32'h0, 1, 0, 2'b01, 0, 1, 32'h0);
    issue(0, 32'h128, 1, 5'd14, 32'h5000, 32'h0, 1, 0, 2'b10, 0, 1, 32'h0);
    // Reset asserted in the third BUSY cycle of a pending load
    instr_valid_ex_i = 1; pc_ex_i = 32'h500; rf_we_ex_i = 1; wr_ex_i = 5'd3;
    alu_res_ex_i = 32'h4000; wdata_ex_i = 32'h11223344; mem_re_i = 1; mem_we_i = 0;
    mem_size_i = 2'b10; mem_unsigned_i = 0; dmem_ack_i = 0;
    bq.push_back('{1'b0, 32'h4000, 4'hF, 32'h11223344});
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    check("rst_mid_valid", {31'd0, instr_valid_mem_o}, 32'd0);
    instr_valid_ex_i = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ack_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("late_ack_stall", {31'd0, stall_o}, 32'd0);
      check("late_ack_req", {31'd0, dmem_req_o}, 32'd0);
    end
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    // Load then x0-destination ALU op back to back
    issue(1, 32'h600, 1, 5'd4, 32'h6000, 32'h0, 1, 0, 2'b10, 0, 1, 32'h0BADF00D);
    issue(1, 32'h604, 1, 5'd0, 32'h00000042, 32'h0, 0, 0, 2'b00, 0, 1, 32'h0);
    // Randomized mix
    for (int t = 0; t < 250; t++) begin
      int   kind, ac;
      logic [1:0] sz;
      kind = int'($urandom_range(0, 3));
      sz   = 2'($urandom_range(0, 2));
      ac   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(MW - 1, MW + 2))
                                          : int'($urandom_range(1, 4));
      issue(kind != 3, $urandom, 1'($urandom), 5'($urandom), $urandom, $urandom,
            kind == 1 || (kind == 3 && $urandom_range(0, 1) == 1), kind == 2, sz,
            1'($urandom), ac, $urandom);
    end
    instr_valid_ex_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("results_drained", eq.size(), 32'd0);
    check("bus_drained", bq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The parameter list SHALL be, one per line:
  MAX_WAIT, 15, BUSY cycles without ack before timeout abort (1..255)
REQ-002 The port list SHALL be, one per line:
  clk  in  1  clock, rising-edge
  rst_n  in  1  reset, asynchronous, active-low
  instr_valid_ex_i  in  1  EX/MEM slot holds a valid instruction
  pc_ex_i  in  32  instruction PC
  rf_we_ex_i  in  1  instruction writes register file
  wr_ex_i  in  5  destination register
  alu_res_ex_i  in  32  ALU result / effective address
  wdata_ex_i  in  32  store data (rs2)
  mem_re_i  in  1  load
  mem_we_i  in  1  store
  mem_size_i  in  2  00 byte, 01 half, 10 word
  mem_unsigned_i  in  1  zero-extend load
  dmem_req_o  out  1  bus request
  dmem_we_o  out  1  bus write
  dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
  dmem_be_o  out  4  byte enables
  dmem_wdata_o  out  32  lane-replicated store data
  dmem_ack_i  in  1  bus completion; rdata valid same cycle
  dmem_rdata_i  in  32  read word
  stall_o  out  1  hold EX/MEM and earlier stages
  pc_mem_o, instr_valid_mem_o, rf_we_mem_o, wr_mem_o, wd_mem_o  out  32/1/1/5/32  registered result to MEM/WB
  misalign_o  out  1  one-cycle pulse, misaligned access dropped
  timeout_o  out  1  one-cycle pulse, bus access aborted

Function
REQ-003 The unit SHALL implement FSM states IDLE and BUSY.
REQ-004 Non-memory instruction (valid, !re, !we) in IDLE SHALL be registered to outputs in one cycle; wd_mem_o=alu_res_ex_i; stall_o=0.
REQ-005 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0; SHALL issue no bus request, emit instruction next cycle with rf_we_mem_o=0, pulse misalign_o; stall_o=0.
REQ-006 Aligned load/store accepted in IDLE SHALL latch all inputs, assert dmem_req_o next cycle, enter BUSY.
REQ-007 stall_o SHALL equal (IDLE & accepting memory op) | (BUSY & !dmem_ack_i), combinational.
REQ-008 In BUSY, dmem_req_o/we/addr/be/wdata SHALL stay constant until ack or timeout; instr_valid_mem_o=0 in every BUSY cycle (bubble).
REQ-009 On dmem_ack_i in BUSY: next cycle outputs carry latched instruction, instr_valid_mem_o=1, dmem_req_o=0, state IDLE; new instruction accepted next cycle at earliest.
REQ-010 dmem_ack_i outside BUSY SHALL be ignored.
REQ-011 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; loads drive the same BE.
REQ-012 Store data: byte replicated x4, half replicated x2, word unchanged; stores force rf_we_mem_o=0.
REQ-013 Load result: rdata>>(8*addr[1:0]), truncated to size, sign-extended unless mem_unsigned_i; registered into wd_mem_o.
REQ-014 wr_mem_o==0 SHALL force rf_we_mem_o=0.
REQ-015 8-bit wait counter SHALL clear on BUSY entry, increment each BUSY cycle without ack; on reaching MAX_WAIT: drop req, emit instruction with rf_we_mem_o=0, pulse timeout_o, return IDLE, deassert stall_o that cycle.
REQ-016 Ack in the same cycle the counter reaches MAX_WAIT SHALL be treated as ack (no timeout).
REQ-017 instr_valid_ex_i=0 in IDLE SHALL produce instr_valid_mem_o=0, rf_we_mem_o=0, no request.

Reset
REQ-018 rst_n low SHALL immediately force IDLE, counter 0, dmem_req_o=0, stall_o=0, all registered outputs 0, including mid-BUSY.
REQ-019 First accept after rst_n release SHALL be on the first rising clk with rst_n high.

Verification
REQ-020 LB addr 0x1003, rdata 0x80xxxxxx, ack after 2 BUSY cycles -> be=1000, stall high 2 cycles, wd_mem_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-021 SH addr 0x2002, wdata 0x0000BEEF -> dmem_wdata_o=0xBEEFBEEF, be=1100, rf_we_mem_o=0.
REQ-022 LW addr 0x3001 -> no dmem_req_o, misalign_o one cycle, rf_we_mem_o=0.
REQ-023 LW with no ack, MAX_WAIT=15 -> req held 15 cycles, timeout_o pulse, stall drops, valid=1 with rf_we=0.
REQ-024 rst_n low in BUSY cycle 3 -> req and stall drop asynchronously; later ack ignored.
REQ-025 ADD wr=x0 back-to-back after load -> one-cycle pass-through, rf_we_mem_o=0.
